// File: rtl/ad9361_samp_gate.sv
// Per-channel signal-presence gate for the AD9361 receive path: |I|+|Q| boxcar
// average drives a hysteresis/hang FSM that gates a fixed-latency I/Q delay line.
module ad9361_samp_gate #(
  parameter int NUM_CHAN           = 4,
  parameter int DATA_WIDTH         = 12,
  parameter int NUM_DELAY          = 24,
  parameter int LOG2_FILTER_LENGTH = 4,
  parameter int HANG_CYCLES        = 16,
  localparam int MW = DATA_WIDTH + 1,
  localparam int SW = MW + LOG2_FILTER_LENGTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           bypass,
  input  logic [MW-1:0]                  thresh_on,
  input  logic [MW-1:0]                  thresh_off,
  input  logic [NUM_CHAN-1:0]            valid_in,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] data_i_in,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] data_q_in,
  output logic [NUM_CHAN-1:0]            valid_out,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] data_i_out,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] data_q_out,
  output logic [NUM_CHAN-1:0]            gate_open
);

  localparam int FL = 1 << LOG2_FILTER_LENGTH;
  localparam int HW = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;
  localparam logic [HW-1:0] HANG_LAST = HW'(HANG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_HANG = 2'd2
  } state_t;

  // Closing never uses a level above the opening level, so hysteresis cannot invert.
  logic [MW-1:0] thresh_off_eff;
  assign thresh_off_eff = (thresh_off < thresh_on) ? thresh_off : thresh_on;

  genvar n;
  generate
    for (n = 0; n < NUM_CHAN; n++) begin : g_chan
      logic [DATA_WIDTH-1:0] i_in, q_in;
      logic [MW-1:0]         i_ext, q_ext, abs_i, abs_q;
      logic [MW-1:0]         mag_d, mag_q;
      logic                  mag_vld_d, mag_vld_q;
      logic [FL-1:0][MW-1:0] hist_d, hist_q;
      logic [SW-1:0]         sum_d, sum_q, avg;
      logic                  sum_vld_d, sum_vld_q;
      state_t                state_d, state_q;
      logic [HW-1:0]         cnt_d, cnt_q;
      logic [NUM_DELAY-2:0]                 dv_d, dv_q;
      logic [NUM_DELAY-2:0][DATA_WIDTH-1:0] di_d, di_q, dq_d, dq_q;
      logic                  vo_d, vo_q;
      logic [DATA_WIDTH-1:0] io_d, io_q, qo_d, qo_q;

      assign i_in  = data_i_in[n*DATA_WIDTH +: DATA_WIDTH];
      assign q_in  = data_q_in[n*DATA_WIDTH +: DATA_WIDTH];
      // One extra bit so |-2^(W-1)| is representable without wrapping.
      assign i_ext = {i_in[DATA_WIDTH-1], i_in};
      assign q_ext = {q_in[DATA_WIDTH-1], q_in};
      assign abs_i = i_in[DATA_WIDTH-1] ? (~i_ext + MW'(1)) : i_ext;
      assign abs_q = q_in[DATA_WIDTH-1] ? (~q_ext + MW'(1)) : q_ext;
      assign avg   = sum_q >> LOG2_FILTER_LENGTH;

      always_comb begin
        mag_d     = abs_i + abs_q;
        mag_vld_d = valid_in[n];
        sum_vld_d = mag_vld_q;
        hist_d    = hist_q;
        sum_d     = sum_q;
        // Filter only ages on valid samples; idle gaps leave the average frozen.
        if (mag_vld_q) begin
          hist_d = {hist_q[FL-2:0], mag_q};
          sum_d  = sum_q + SW'(mag_q) - SW'(hist_q[FL-1]);
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        if (sum_vld_q) begin
          case (state_q)
            ST_IDLE: if (avg >= SW'(thresh_on)) state_d = ST_OPEN;
            ST_OPEN: begin
              if (avg < SW'(thresh_off_eff)) begin
                state_d = ST_HANG;
                cnt_d   = '0;
              end
            end
            ST_HANG: begin
              if (avg >= SW'(thresh_on))  state_d = ST_OPEN;
              else if (cnt_q == HANG_LAST) state_d = ST_IDLE;
              else                         cnt_d   = cnt_q + HW'(1);
            end
            default: state_d = ST_IDLE;
          endcase
        end

        dv_d = {dv_q[NUM_DELAY-3:0], valid_in[n]};
        di_d = {di_q[NUM_DELAY-3:0], i_in};
        dq_d = {dq_q[NUM_DELAY-3:0], q_in};
        // Gate against the state that will be visible alongside this output.
        vo_d = dv_q[NUM_DELAY-2] & ((state_d != ST_IDLE) | bypass);
        io_d = di_q[NUM_DELAY-2];
        qo_d = dq_q[NUM_DELAY-2];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mag_q     <= '0;
          mag_vld_q <= 1'b0;
          hist_q    <= '0;
          sum_q     <= '0;
          sum_vld_q <= 1'b0;
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          dv_q      <= '0;
          di_q      <= '0;
          dq_q      <= '0;
          vo_q      <= 1'b0;
          io_q      <= '0;
          qo_q      <= '0;
        end else begin
          mag_q     <= mag_d;
          mag_vld_q <= mag_vld_d;
          hist_q    <= hist_d;
          sum_q     <= sum_d;
          sum_vld_q <= sum_vld_d;
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          dv_q      <= dv_d;
          di_q      <= di_d;
          dq_q      <= dq_d;
          vo_q      <= vo_d;
          io_q      <= io_d;
          qo_q      <= qo_d;
        end
      end

      assign valid_out[n]                             = vo_q;
      assign data_i_out[n*DATA_WIDTH +: DATA_WIDTH]   = io_q;
      assign data_q_out[n*DATA_WIDTH +: DATA_WIDTH]   = qo_q;
      assign gate_open[n]                             = (state_q != ST_IDLE);
    end
  endgenerate

endmodule

// File: tb/tb_ad9361_samp_gate.sv
// Bench for ad9361_samp_gate: cycle model of filter/gate plus a delay-line
// scoreboard, with directed timing checks for open/close/hang/bypass/reset.
module tb_ad9361_samp_gate;

  localparam int NC   = 4;
  localparam int DW   = 12;
  localparam int ND   = 24;
  localparam int MW   = DW + 1;
  localparam int FLEN = 16;
  localparam int HANG = 16;
  localparam int W    = NC + 2 * NC * DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              bypass;
  logic [MW-1:0]     thresh_on, thresh_off;
  logic [NC-1:0]     valid_in;
  logic [NC*DW-1:0]  data_i_in, data_q_in;
  logic [NC-1:0]     valid_out, gate_open;
  logic [NC*DW-1:0]  data_i_out, data_q_out;

  ad9361_samp_gate dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bypass     (bypass),
    .thresh_on  (thresh_on),
    .thresh_off (thresh_off),
    .valid_in   (valid_in),
    .data_i_in  (data_i_in),
    .data_q_in  (data_q_in),
    .valid_out  (valid_out),
    .data_i_out (data_i_out),
    .data_q_out (data_q_out),
    .gate_open  (gate_open)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard: inputs queued at drive time, popped NUM_DELAY cycles later.
  logic [W-1:0] exp_q[$];

  // Reference model state (filter as explicit window, FSM per channel)
  int          hist[NC][FLEN];
  logic        p_v[NC][2];
  int          p_m[NC][2];
  int          m_state[NC];
  int          m_cnt[NC];
  logic [NC-1:0]    m_gate, exp_vo;
  logic [NC*DW-1:0] exp_di, exp_dq;
  logic             vin_hist[64];

  function automatic int absv(input logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NC; ch++) begin
      for (int k = 0; k < FLEN; k++) hist[ch][k] = 0;
      p_v[ch][0] = 1'b0; p_v[ch][1] = 1'b0;
      p_m[ch][0] = 0;    p_m[ch][1] = 0;
      m_state[ch] = 0;
      m_cnt[ch]   = 0;
    end
    m_gate = '0; exp_vo = '0; exp_di = '0; exp_dq = '0;
    exp_q.delete();
    repeat (ND - 1) exp_q.push_back('0);
  endtask

  // Called at each rising edge, before the DUT registers update.
  task automatic model_edge();
    logic [W-1:0] ent;
    logic ev;
    int em, s, avg, on_i, off_eff;
    if (!rst_n) begin
      model_reset();
    end else begin
      on_i    = int'(thresh_on);
      off_eff = (thresh_off < thresh_on) ? int'(thresh_off) : on_i;
      for (int ch = 0; ch < NC; ch++) begin
        ev = p_v[ch][1];
        em = p_m[ch][1];
        p_v[ch][1] = p_v[ch][0];
        p_m[ch][1] = p_m[ch][0];
        p_v[ch][0] = valid_in[ch];
        p_m[ch][0] = absv(data_i_in[ch*DW +: DW]) + absv(data_q_in[ch*DW +: DW]);
        if (ev) begin
          for (int k = FLEN - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
          hist[ch][0] = em;
          s = 0;
          for (int k = 0; k < FLEN; k++) s += hist[ch][k];
          avg = s / FLEN;
          case (m_state[ch])
            0: if (avg >= on_i) m_state[ch] = 1;
            1: if (avg < off_eff) begin m_state[ch] = 2; m_cnt[ch] = 0; end
            default: begin
              if (avg >= on_i)             m_state[ch] = 1;
              else if (m_cnt[ch] == HANG-1) m_state[ch] = 0;
              else                          m_cnt[ch]++;
            end
          endcase
        end
        m_gate[ch] = (m_state[ch] != 0);
      end
      exp_q.push_back({valid_in, data_i_in, data_q_in});
      ent    = exp_q.pop_front();
      exp_vo = ent[W-1 -: NC] & (m_gate | {NC{bypass}});
      exp_di = ent[2*NC*DW-1 -: NC*DW];
      exp_dq = ent[NC*DW-1:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("gate_open",  gate_open,  m_gate);
    check("valid_out",  valid_out,  exp_vo);
    check("data_i_out", data_i_out, exp_di);
    check("data_q_out", data_q_out, exp_dq);
  endtask

  // Driver tasks
  task automatic drive(input int ch, input logic v, input int i, input int q);
    valid_in[ch]           = v;
    data_i_in[ch*DW +: DW] = i[DW-1:0];
    data_q_in[ch*DW +: DW] = q[DW-1:0];
  endtask

  task automatic noise(input int keep);
    for (int ch = 0; ch < NC; ch++)
      if (ch != keep)
        drive(ch, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)) - 10,
              int'($urandom_range(0, 20)) - 10);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    check({tag, "_valid_out"}, valid_out, '0);
    check({tag, "_gate"}, gate_open, '0);
    check({tag, "_data_i"}, data_i_out, '0);
    check({tag, "_data_q"}, data_q_out, '0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int lows, stale;
    rst_n = 1'b0; bypass = 1'b0;
    thresh_on = 13'd50; thresh_off = 13'd30;
    valid_in = '0; data_i_in = '0; data_q_in = '0;
    tick(); tick();
    do_reset("t1_rst");

    // Test 1: ch0 I=100 opens at cycle 10, first valid_out at 24
    for (int c = 0; c < 40; c++) begin
      noise(0); drive(0, 1'b1, 100, 0);
      tick();
      if (cyc == 9)  check("t1_gate_c9",  gate_open[0], 1'b0);
      if (cyc == 10) check("t1_gate_c10", gate_open[0], 1'b1);
      if (cyc == 23) check("t1_vout_c23", valid_out[0], 1'b0);
      if (cyc == 24) begin
        check("t1_vout_c24", valid_out[0], 1'b1);
        check("t1_data_c24", data_i_out[DW-1:0], 12'd100);
      end
      if (cyc == 30) check("t1_others_closed", gate_open[NC-1:1], '0);
    end

    // Test 2: zeros from c0=40; HANG at 54, IDLE at 70
    for (int c = 40; c < 80; c++) begin
      noise(0); drive(0, 1'b1, 0, 0);
      tick();
      if (cyc == 53) check("t2_gate_c53", gate_open[0], 1'b1);
      if (cyc == 69) begin
        check("t2_gate_c69", gate_open[0], 1'b1);
        check("t2_vout_c69", valid_out[0], 1'b1);
      end
      if (cyc == 70) begin
        check("t2_gate_c70", gate_open[0], 1'b0);
        check("t2_vout_c70", valid_out[0], 1'b0);
      end
    end

    // Test 3: reopen, decay into HANG, re-trigger before hang expires
    lows = 0;
    for (int c = 80; c < 150; c++) begin
      noise(0);
      drive(0, 1'b1, (c >= 110 && c < 126) ? 0 : 100, 0);
      tick();
      if (cyc == 89) check("t3_gate_c89", gate_open[0], 1'b0);
      if (cyc >= 90 && !gate_open[0]) lows++;
    end
    check("t3_gate_hold", lows, 0);

    // Test 4: valid every other cycle; opens at cycle 17
    do_reset("t4_rst");
    for (int c = 0; c < 50; c++) begin
      noise(0); drive(0, 1'((c % 2) == 0), 100, 0);
      tick();
      if (cyc == 16) check("t4_gate_c16", gate_open[0], 1'b0);
      if (cyc == 17) check("t4_gate_c17", gate_open[0], 1'b1);
    end

    // Test 5: full-scale negative sample, thresh_off above thresh_on
    thresh_off = 13'd80;
    do_reset("t5_rst");
    for (int c = 0; c < 100; c++) begin
      noise(1);
      if (c == 0)      drive(1, 1'b1, -2048, -2048);
      else if (c < 60) drive(1, 1'b1, 60, 0);
      else             drive(1, 1'b1, 40, 0);
      tick();
      if (cyc == 2)  check("t5_gate_c2",  gate_open[1], 1'b0);
      if (cyc == 3)  check("t5_gate_c3",  gate_open[1], 1'b1);
      if (cyc == 50) check("t5_gate_c50", gate_open[1], 1'b1);
      if (cyc == 86) check("t5_gate_c86", gate_open[1], 1'b1);
      if (cyc == 87) check("t5_gate_c87", gate_open[1], 1'b0);
    end

    // Test 6: bypass, then one-cycle reset mid-stream
    bypass = 1'b1; thresh_on = 13'h1fff; thresh_off = 13'h1fff;
    do_reset("t6_rst");
    for (int c = 0; c < 40; c++) begin
      noise(-1);
      vin_hist[c] = valid_in[0];
      tick();
      if (cyc >= 24) check("t6_bypass", valid_out[0], vin_hist[cyc-24]);
    end
    noise(-1);
    do_reset("t6_mid_rst");
    stale = 0;
    for (int c = 0; c < 30; c++) begin
      noise(-1); valid_in = '0;
      tick();
      if (valid_out != '0) stale++;
    end
    check("t6_no_stale", stale, 0);
    for (int c = 0; c < 30; c++) begin
      noise(-1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
